// File: rtl/lfsr_pkg.sv
// Shared constants for the lfsr_gen word source: default polynomial/seed and FSM encoding.
package lfsr_pkg;

  // x^128 + x^29 + x^27 + x^2 + 1
  localparam logic [127:0] LFSR_DEF_POLY128 = 128'h28000005;
  localparam logic [127:0] LFSR_DEF_SEED    = 128'h53504402;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  typedef logic [31:0] word_cnt_t;

endpackage

// File: rtl/lfsr_gen_if.sv
// Output handshake and seed-load bundle for lfsr_gen; master = generator, slave = consumer.
interface lfsr_gen_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 128
) ();

  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             rand_ready;
  logic             rand_valid;
  logic [WIDTH-1:0] rand_data;
  word_cnt_t        word_cnt;
  logic             zero_fault;

  modport master (
    input  seed_load, seed, rand_ready,
    output rand_valid, rand_data, word_cnt, zero_fault
  );

  modport slave (
    output seed_load, seed, rand_ready,
    input  rand_valid, rand_data, word_cnt, zero_fault
  );

endinterface

// File: rtl/lfsr_adv.sv
// Combinational Galois LFSR advance: STEPS single-bit shifts unrolled in one cycle.
module lfsr_adv
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_DEF_POLY128),
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  // Stage 0 always takes the feedback, so bit 0 of POLY is masked off.
  localparam logic [WIDTH-1:0] TAPS = {POLY[WIDTH-1:1], 1'b0};

  logic [WIDTH-1:0] s;
  logic             fb;

  // NOTE: combinational logic uses blocking '=' and assigns every variable up front, so no latch is inferred.
  always_comb begin
    s  = state_i;
    fb = 1'b0;
    for (int k = 0; k < STEPS; k++) begin
      fb = s[WIDTH-1];
      s  = {s[WIDTH-2:0], fb} ^ (TAPS & {WIDTH{fb}});
    end
    state_o = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR word source with valid/ready holding register and accepted-word counter.
// Optional all-zero seed guard enabled by defining LFSR_ZERO_GUARD_EN.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_DEF_POLY128),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEF_SEED),
  parameter int               STEPS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_gen_if.master bus
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  word_cnt_t        word_cnt_q, word_cnt_d;
  logic [0:0]       fsm_q, fsm_d;
  logic [WIDTH-1:0] state_adv;
  logic [WIDTH-1:0] load_val;

  lfsr_adv #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .STEPS (STEPS)
  ) u_adv (
    .state_i (state_q),
    .state_o (state_adv)
  );

`ifdef LFSR_ZERO_GUARD_EN
  logic fault_q, fault_d;
  logic seed_zero;

  // A zero state would lock the LFSR forever, so substitute the default seed.
  assign seed_zero = (bus.seed == '0);
  assign load_val  = seed_zero ? SEED : bus.seed;
  assign fault_d   = fault_q | (bus.seed_load & seed_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign bus.zero_fault = fault_q;
`else
  assign load_val       = bus.seed;
  assign bus.zero_fault = 1'b0;
`endif

  // seed_load outranks everything; a handshake in the same cycle is dropped.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    fsm_d      = fsm_q;
    if (bus.seed_load) begin
      state_d    = load_val;
      word_cnt_d = '0;
      fsm_d      = ST_FILL;
    end else if (fsm_q == ST_FILL) begin
      data_d  = state_q;
      state_d = state_adv;
      fsm_d   = ST_VALID;
    end else if (bus.rand_ready) begin
      data_d     = state_q;
      state_d    = state_adv;
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED;
      data_q     <= '0;
      word_cnt_q <= '0;
      fsm_q      <= ST_FILL;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
      fsm_q      <= fsm_d;
    end
  end

  assign bus.rand_valid = (fsm_q == ST_VALID);
  assign bus.rand_data  = data_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: behavioural word-stream model plus directed literal checks.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  localparam logic [127:0] POLY = LFSR_DEF_POLY128;
  localparam logic [127:0] SEED = LFSR_DEF_SEED;
`ifdef LFSR_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  lfsr_gen_if #(.WIDTH(128)) u_if ();
  lfsr_gen_if #(.WIDTH(128)) u_if4 ();

  lfsr_gen #(.WIDTH(128), .STEPS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  lfsr_gen #(.WIDTH(128), .STEPS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial view of a Galois step: multiply by x, reduce by the tap mask when the top bit falls out.
  function automatic logic [127:0] adv(input logic [127:0] s, input int n);
    logic [127:0] r;
    r = s;
    for (int k = 0; k < n; k++)
      r = r[127] ? ((r << 1) ^ (POLY | 128'd1)) : (r << 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: next word to hand out, current word, validity, accepted count, sticky fault.
  logic [127:0] m_next, m_data, m4_next, m4_data;
  logic         m_valid, m4_valid, m_fault;
  logic [31:0]  m_cnt;
  logic         force_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_next = SEED; m_data = '0; m_valid = 1'b0; m_cnt = '0; m_fault = 1'b0;
      m4_next = SEED; m4_data = '0; m4_valid = 1'b0;
    end else begin
      if (u_if.seed_load) begin
        if (GUARD && u_if.seed == '0) begin
          m_next  = SEED;
          m_fault = 1'b1;
        end else begin
          m_next = u_if.seed;
        end
        m_valid = 1'b0;
        m_cnt   = '0;
      end else if (!m_valid || u_if.rand_ready) begin
        if (m_valid) m_cnt = m_cnt + 32'd1;
        m_data  = m_next;
        m_next  = adv(m_next, 1);
        m_valid = 1'b1;
      end
      if (force_cnt) m_cnt = 32'hFFFF_FFFF;
      m4_data  = m4_next;
      m4_next  = adv(m4_next, 4);
      m4_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", u_if.rand_valid, m_valid);
      if (m_valid) check("data", u_if.rand_data, m_data);
      check("word_cnt", u_if.word_cnt, m_cnt);
      check("zero_fault", u_if.zero_fault, m_fault);
      check("valid4", u_if4.rand_valid, m4_valid);
      if (m4_valid) check("data4", u_if4.rand_data, m4_data);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] held;
    rst_n = 1'b0;
    force_cnt = 1'b0;
    u_if.seed_load = 1'b0; u_if.seed = '0; u_if.rand_ready = 1'b0;
    u_if4.seed_load = 1'b0; u_if4.seed = '0; u_if4.rand_ready = 1'b1;
    #12;
    check("reset valid", u_if.rand_valid, 1'b0);
    check("reset data", u_if.rand_data, 128'd0);
    check("reset cnt", u_if.word_cnt, 32'd0);
    check("reset fault", u_if.zero_fault, 1'b0);

    // Reset release with continuous ready.
    step();
    rst_n = 1'b1;
    u_if.rand_ready = 1'b1;
    step();
    check("first word", u_if.rand_data, 128'h53504402);
    check("first valid", u_if.rand_valid, 1'b1);
    check("step4 word0", u_if4.rand_data, 128'h53504402);
    step();
    check("second word", u_if.rand_data, 128'hA6A08804);
    check("cnt after 1", u_if.word_cnt, 32'd1);
    check("step4 word1", u_if4.rand_data, 128'h535044020);
    step();
    check("third word", u_if.rand_data, 128'h14D411008);
    check("cnt after 2", u_if.word_cnt, 32'd2);

    // Seed load coincident with a handshake.
    u_if.seed_load = 1'b1;
    u_if.seed = 128'd1 << 127;
    step();
    u_if.seed_load = 1'b0;
    check("load gap valid", u_if.rand_valid, 1'b0);
    check("load cnt", u_if.word_cnt, 32'd0);
    step();
    check("load word0", u_if.rand_data, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    check("load cnt0", u_if.word_cnt, 32'd0);
    step();
    check("load word1", u_if.rand_data, 128'h28000005);
    check("load cnt1", u_if.word_cnt, 32'd1);

    // Backpressure for 5 cycles.
    repeat (3) step();
    u_if.rand_ready = 1'b0;
    held = m_data;
    repeat (5) step();
    check("held data", u_if.rand_data, held);
    u_if.rand_ready = 1'b1;
    step();
    check("resume data", u_if.rand_data, adv(held, 1));

    // Randomised ready and occasional seed loads.
    for (int i = 0; i < 400; i++) begin
      u_if.rand_ready = ($urandom_range(3) != 0);
      u_if.seed_load  = ($urandom_range(39) == 0);
      u_if.seed       = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
      step();
    end
    u_if.seed_load = 1'b0;
    u_if.rand_ready = 1'b1;

    // Zero seed.
    u_if.seed_load = 1'b1;
    u_if.seed = '0;
    step();
    u_if.seed_load = 1'b0;
    step();
    check("zero seed word", u_if.rand_data, GUARD ? 128'h53504402 : 128'd0);
    check("zero seed fault", u_if.zero_fault, GUARD);
    repeat (3) step();
    u_if.seed_load = 1'b1;
    u_if.seed = 128'h1234;
    step();
    u_if.seed_load = 1'b0;
    step();
    check("fault sticky", u_if.zero_fault, GUARD);
    check("post-zero load word", u_if.rand_data, 128'h1234);

    // Counter wrap.
    u_if.rand_ready = 1'b0;
    force dut.word_cnt_q = 32'hFFFF_FFFF;
    force_cnt = 1'b1;
    step();
    release dut.word_cnt_q;
    force_cnt = 1'b0;
    u_if.rand_ready = 1'b1;
    step();
    check("cnt wrap", u_if.word_cnt, 32'd0);
    repeat (3) step();

    // Reset asserted mid-stream.
    rst_n = 1'b0;
    #1;
    check("midreset valid", u_if.rand_valid, 1'b0);
    check("midreset data", u_if.rand_data, 128'd0);
    check("midreset cnt", u_if.word_cnt, 32'd0);
    check("midreset fault", u_if.zero_fault, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("rerelease word", u_if.rand_data, 128'h53504402);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
